// File: rtl/vj_weights.sv
// Shared image geometry and UART receive timeout for the integral-image pipeline.
// Macro-only file; safe to compile standalone or include from any design unit.
`ifndef VJ_WEIGHTS_VH
`define VJ_WEIGHTS_VH

`define LAPTOP_WIDTH   24
`define LAPTOP_HEIGHT  24
`define IMG_RX_TIMEOUT 100000

`endif

// File: rtl/img_frame_assembler.sv
// Assembles a row-major stream of UART pixel bytes into a full frame buffer and
// publishes it to laptop_img only once every pixel has arrived; stalled frames time out.
`ifndef VJ_WEIGHTS_VH
`include "vj_weights.sv"
`endif

module img_frame_assembler #(
    parameter int unsigned IMG_WIDTH      = `LAPTOP_WIDTH,
    parameter int unsigned IMG_HEIGHT     = `LAPTOP_HEIGHT,
    parameter int unsigned TIMEOUT_CYCLES = `IMG_RX_TIMEOUT
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic [7:0]                                rx_data,
    input  logic                                      rx_valid,
    output logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][7:0] laptop_img,
    output logic                                      laptop_img_rdy,
    output logic                                      rx_busy,
    output logic [7:0]                                frame_err_count
);

    localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] ColLast  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] RowLast  = RW'(IMG_HEIGHT - 1);
    localparam logic [TW-1:0] IdleLast = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        StIdle,
        StRecv
    } state_e;

    state_e                                   state_q, state_d;
    logic [CW-1:0]                            col_q, col_d;
    logic [RW-1:0]                            row_q, row_d;
    logic [TW-1:0]                            idle_q, idle_d;
    logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][7:0] buf_q, buf_d;
    logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][7:0] img_q, img_d;
    logic                                     rdy_q, rdy_d;
    logic [7:0]                               err_q, err_d;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        idle_d  = idle_q;
        buf_d   = buf_q;
        img_d   = img_q;
        rdy_d   = 1'b0;
        err_d   = err_q;

        if (rx_valid) begin
            // Accepting a byte always wins over a timeout in the same cycle.
            buf_d[row_q][col_q] = rx_data;
            idle_d = '0;
            if (row_q == RowLast && col_q == ColLast) begin
                img_d   = buf_d;
                rdy_d   = 1'b1;
                state_d = StIdle;
                row_d   = '0;
                col_d   = '0;
            end else begin
                state_d = StRecv;
                if (col_q == ColLast) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end else if (state_q == StRecv) begin
            if (idle_q == IdleLast) begin
                state_d = StIdle;
                row_d   = '0;
                col_d   = '0;
                idle_d  = '0;
                if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end else begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            idle_q  <= '0;
            img_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            idle_q  <= idle_d;
            img_q   <= img_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    // Assembly buffer is deliberately unreset; stale contents are overwritten before publish.
    always_ff @(posedge clock) begin
        buf_q <= buf_d;
    end

    assign laptop_img      = img_q;
    assign laptop_img_rdy  = rdy_q;
    assign rx_busy         = (state_q == StRecv);
    assign frame_err_count = err_q;

endmodule

// File: tb/tb_img_frame_assembler.sv
// Directed bench for img_frame_assembler with a 4x3 frame and a 10-cycle timeout.
module tb_img_frame_assembler;

    logic                 clock;
    logic                 reset_n;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [2:0][3:0][7:0] laptop_img;
    logic                 laptop_img_rdy;
    logic                 rx_busy;
    logic [7:0]           frame_err_count;

    int n_vec;
    int n_err;
    int rdy_cnt;

    img_frame_assembler #(
        .IMG_WIDTH      (4),
        .IMG_HEIGHT     (3),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .laptop_img      (laptop_img),
        .laptop_img_rdy  (laptop_img_rdy),
        .rx_busy         (rx_busy),
        .frame_err_count (frame_err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (laptop_img_rdy) rdy_cnt <= rdy_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] ramp(input logic [7:0] base);
        logic [95:0] r;
        for (int k = 0; k < 12; k++) r[k*8 +: 8] = base + 8'(k);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rdy_cnt  = 0;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick(2);
        check_val("reset_img", laptop_img, 96'h0);
        check_val("reset_rdy", 96'(laptop_img_rdy), 96'h0);
        check_val("reset_busy", 96'(rx_busy), 96'h0);
        check_val("reset_err", 96'(frame_err_count), 96'h0);
        reset_n = 1'b1;
        tick(1);

        // Back-to-back frame 0x00..0x0B.
        send(8'h00);
        check_val("a_busy_first", 96'(rx_busy), 96'h1);
        for (int i = 1; i < 11; i++) send(8'(i));
        check_val("a_no_early_rdy", 96'(laptop_img_rdy), 96'h0);
        check_val("a_no_partial_img", laptop_img, 96'h0);
        send(8'h0B);
        check_val("a_px23", 96'(laptop_img[2][3]), 96'h0B);
        check_val("a_px10", 96'(laptop_img[1][0]), 96'h04);
        check_val("a_img", laptop_img, ramp(8'h00));
        check_val("a_rdy", 96'(laptop_img_rdy), 96'h1);
        check_val("a_busy_done", 96'(rx_busy), 96'h0);
        tick(1);
        check_val("a_rdy_drop", 96'(laptop_img_rdy), 96'h0);

        // Same bytes with 9 idle cycles between: one short of timing out each gap.
        for (int i = 0; i < 11; i++) begin
            send(8'(i));
            tick(9);
        end
        check_val("b_busy_gap", 96'(rx_busy), 96'h1);
        send(8'h0B);
        check_val("b_rdy", 96'(laptop_img_rdy), 96'h1);
        check_val("b_err", 96'(frame_err_count), 96'h0);
        check_val("b_img", laptop_img, ramp(8'h00));

        // Partial frame then timeout.
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
        tick(9);
        check_val("c_busy_pre", 96'(rx_busy), 96'h1);
        check_val("c_err_pre", 96'(frame_err_count), 96'h0);
        tick(1);
        check_val("c_busy_to", 96'(rx_busy), 96'h0);
        check_val("c_err_to", 96'(frame_err_count), 96'h1);
        check_val("c_img_kept", laptop_img, ramp(8'h00));
        for (int i = 0; i < 12; i++) send(8'hA0 + 8'(i));
        check_val("c_px00", 96'(laptop_img[0][0]), 96'hA0);
        check_val("c_img", laptop_img, ramp(8'hA0));
        check_val("c_err_keep", 96'(frame_err_count), 96'h1);

        // Next frame starts the cycle right after completion.
        tick(1);
        rdy_cnt = 0;
        for (int i = 0; i < 12; i++) send(8'h30 + 8'(i));
        send(8'hFF);
        check_val("d_img_f1", laptop_img, ramp(8'h30));
        check_val("d_busy", 96'(rx_busy), 96'h1);
        for (int i = 1; i < 11; i++) send(8'h70 + 8'(i));
        check_val("d_img_hold", laptop_img, ramp(8'h30));
        send(8'h7B);
        check_val("d_img_f2", laptop_img, {ramp(8'h70)[95:8], 8'hFF});
        tick(1);
        check_val("d_rdy_count", 96'(rdy_cnt), 96'h2);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 7; i++) send(8'h11 + 8'(i));
        #2 reset_n = 1'b0;
        #1;
        check_val("e_img", laptop_img, 96'h0);
        check_val("e_busy", 96'(rx_busy), 96'h0);
        check_val("e_err", 96'(frame_err_count), 96'h0);
        check_val("e_rdy", 96'(laptop_img_rdy), 96'h0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        for (int i = 0; i < 12; i++) send(8'h60 + 8'(i));
        check_val("e_img_new", laptop_img, ramp(8'h60));
        check_val("e_err_new", 96'(frame_err_count), 96'h0);

        // Saturation of the discard counter.
        for (int i = 0; i < 255; i++) begin
            send(8'h01);
            tick(10);
        end
        check_val("f_err_255", 96'(frame_err_count), 96'hFF);
        send(8'h01);
        tick(10);
        check_val("f_err_sat", 96'(frame_err_count), 96'hFF);
        check_val("f_img_kept", laptop_img, ramp(8'h60));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
